alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Sequencing controller for the 16-bit ALU. Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 16×16 register file. It drives the external combinational ALU, then writes the result back and latches the ALU flags into a processor status register (PSR). This is the execute/writeback stage that turns the ALU into a working datapath.

## Interface
Parameters:
- `NREGS`, 16: register-file depth. Fixed at 16, because register specifiers are 4 bits.
- `W`, 16: datapath width. Must match the ALU.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  controller can accept an instruction.
- `instr_op`  in  8  opcode, ALU encoding.
- `instr_rdest`  in  4  destination register, also the A-operand register.
- `instr_rsrc`  in  4  source register for register forms.
- `instr_imm`  in  8  immediate for immediate forms.
- `alu_a`  out  16  to ALU `Rdest`.
- `alu_b`  out  16  to ALU `Rsrc_Imm`.
- `alu_op`  out  8  to ALU `Opcode`.
- `alu_result`  in  16  from ALU `Result`.
- `alu_flags`  in  5  from ALU `Flags`, bit order {L,C,F,Z,N}.
- `psr`  out  5  latched flags, same bit order.
- `done`  out  1  one-cycle pulse on retirement.
- `illegal`  out  1  valid with `done`; high when the retired opcode was illegal.
- `dbg_addr`  in  4  debug read address.
- `dbg_data`  out  16  combinational read of `rf[dbg_addr]`.

## Operation
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid`&&`instr_ready`, latch op, rdest, rsrc and imm into `q_*`, then go to EXEC.
- EXEC:
  - `alu_op`=`q_op` and `alu_a`=`rf[q_rdest]`.
  - `alu_b` is `rf[q_rsrc]` when `q_op[7:4]`==0 (register form), otherwise `{{8{q_imm[7]}},q_imm}` (immediate form, sign-extended).
  - At the clock edge, register `alu_result`→`res_q` and `alu_flags`→`flg_q`, then go to WB.
- WB:
  - Writeback `rf[q_rdest]`←`res_q` happens for every legal opcode except CMP (0x0B), CMPI (0xB0) and WAIT (0x00).
  - The PSR update `psr`←`flg_q` happens for every legal opcode except WAIT.
  - Pulse `done`. Set `illegal` as defined below. Go to IDLE.
- Legal opcodes: 0x00–0x09, 0x0B–0x0F, 0x50, 0x60, 0x70, 0x80, 0x90, 0xB0, 0xC0, 0xD0, 0xE0, 0xF0.
- Illegal opcodes: everything else, including SUBC 0x0A and SUBCI 0xA0.
  - An illegal opcode still retires through EXEC/WB.
  - It performs no register write and no PSR update.
  - `done`=1 and `illegal`=1 in WB.
- `alu_op`, `alu_a` and `alu_b` outside EXEC: they continue to reflect the latched fields, and their values there are don't-care.
- When `rdest`==`rsrc` in a register form, the same register feeds both operands. The read in EXEC precedes the write in WB, so there is no hazard.

## Timing
- Reset (async, `reset_n`=0):
  - State is IDLE.
  - All `rf` entries are 0, `psr`=0, `res_q`=0, `flg_q`=0 and `q_*`=0.
  - `done`=0, `illegal`=0, `instr_ready`=1 after release.
  - Reset mid-instruction aborts it: no write, no `done`.
- Latency, with handshake in cycle 0:
  - EXEC in cycle 1.
  - WB and `done` in cycle 2.
  - `rf` and `psr` are visible from cycle 3.
  - `instr_ready` is high again in cycle 3.
- Throughput: one instruction per 3 cycles.
- While `instr_valid` is held high, the next handshake happens in cycle 3.
- `instr_ready`=0 in EXEC and WB. Inputs presented then are ignored and not latched.
- `dbg_data` is combinational. The WB write is visible to `dbg_data` from the following cycle.

## Configuration
- `ALU_SEQ_R0_ZERO_EN` defined:
  - Register 0 is hard-wired to 0. Reads of r0, including `dbg_data`, return 0, and writes to r0 are discarded.
  - The PSR still updates normally on instructions targeting r0.
- `ALU_SEQ_R0_ZERO_EN` undefined: r0 is an ordinary register.

## Test plan
- Reset, then `dbg_addr`=0..15: every read is 0, `psr`=0, `instr_ready`=1.
- ADDI r1,#5 (0x50, rdest=1, imm=0x05), then ADD r2,r1 (0x05, rdest=2, rsrc=1) with r2=0:
  - r1=0x0005 and r2=0x0005.
  - Then ADD r1,r1 gives r1=0x000A.
  - `done` pulses exactly 2 cycles after each handshake.
- MOVI r3,#-1 (0xD0, imm=0xFF):
  - r3=0xFFFF and `psr`[0]=1 (N).
  - Then CMPI r3,#-1: r3 stays 0xFFFF and `psr`[1]=1 (Z).
- Opcode 0x0A with r4=0x1234 and `psr` nonzero:
  - `done`=1 and `illegal`=1.
  - r4 and `psr` are unchanged.
- `instr_valid` held high for 3 instructions:
  - Handshakes land in cycles 0, 3 and 6.
  - `instr_ready` is low in cycles 1–2 and 4–5.
- Reset asserted during EXEC of MOVI r5,#7: r5=0, no `done`, state IDLE.
  - With `ALU_SEQ_R0_ZERO_EN` defined: MOVI r0,#9 leaves r0 reading 0, and `psr`[1]=0.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Execute/writeback sequencer for the 16-bit ALU: register file, IDLE/EXEC/WB FSM and PSR.
// Optional build macro ALU_SEQ_R0_ZERO_EN hard-wires r0 to zero.
module alu_seq_ctrl #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned W     = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [7:0]   instr_op,
  input  logic [3:0]   instr_rdest,
  input  logic [3:0]   instr_rsrc,
  input  logic [7:0]   instr_imm,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [7:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic [4:0]   alu_flags,
  output logic [4:0]   psr,
  output logic         done,
  output logic         illegal,
  input  logic [3:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t       state_q, state_d;
  logic [7:0]   op_q, op_d;
  logic [3:0]   rdest_q, rdest_d;
  logic [3:0]   rsrc_q, rsrc_d;
  logic [7:0]   imm_q, imm_d;
  logic [W-1:0] res_q, res_d;
  logic [4:0]   flg_q, flg_d;
  logic [4:0]   psr_q, psr_d;
  logic         done_q, done_d;
  logic         illegal_q, illegal_d;
  logic         ready_q, ready_d;
  logic [W-1:0] rf_q [NREGS];
  logic [W-1:0] rf_d [NREGS];

  logic [W-1:0] rd_dest, rd_src, rd_dbg;
  logic         op_legal, wr_en, psr_en;

  function automatic logic op_is_legal(input logic [7:0] op);
    if (op[7:4] == 4'h0) return op[3:0] != 4'hA;
    return (op[3:0] == 4'h0) && !(op[7:4] inside {4'h1, 4'h2, 4'h3, 4'h4, 4'hA});
  endfunction

  always_comb begin
    rd_dest = rf_q[rdest_q];
    rd_src  = rf_q[rsrc_q];
    rd_dbg  = rf_q[dbg_addr];
`ifdef ALU_SEQ_R0_ZERO_EN
    if (rdest_q == 4'd0)  rd_dest = '0;
    if (rsrc_q == 4'd0)   rd_src  = '0;
    if (dbg_addr == 4'd0) rd_dbg  = '0;
`endif
  end

  assign op_legal = op_is_legal(op_q);
  assign psr_en   = op_legal && (op_q != 8'h00);
`ifdef ALU_SEQ_R0_ZERO_EN
  assign wr_en    = psr_en && (op_q != 8'h0B) && (op_q != 8'hB0) && (rdest_q != 4'd0);
`else
  assign wr_en    = psr_en && (op_q != 8'h0B) && (op_q != 8'hB0);
`endif

  assign alu_op      = op_q;
  assign alu_a       = rd_dest;
  assign alu_b       = (op_q[7:4] == 4'h0) ? rd_src : {{(W-8){imm_q[7]}}, imm_q};
  assign psr         = psr_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign instr_ready = ready_q;
  assign dbg_data    = rd_dbg;

  // done/illegal are registered, so they are raised on the EXEC->WB edge to be high during WB.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rdest_d   = rdest_q;
    rsrc_d    = rsrc_q;
    imm_d     = imm_q;
    res_d     = res_q;
    flg_d     = flg_q;
    psr_d     = psr_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    rf_d      = rf_q;
    unique case (state_q)
      IDLE: begin
        if (instr_valid) begin
          op_d    = instr_op;
          rdest_d = instr_rdest;
          rsrc_d  = instr_rsrc;
          imm_d   = instr_imm;
          ready_d = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d     = alu_result;
        flg_d     = alu_flags;
        done_d    = 1'b1;
        illegal_d = !op_legal;
        state_d   = WB;
      end
      WB: begin
        if (wr_en)  rf_d[rdest_q] = res_q;
        if (psr_en) psr_d = flg_q;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rdest_q   <= '0;
      rsrc_q    <= '0;
      imm_q     <= '0;
      res_q     <= '0;
      flg_q     <= '0;
      psr_q     <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      ready_q   <= 1'b1;
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rdest_q   <= rdest_d;
      rsrc_q    <= rsrc_d;
      imm_q     <= imm_d;
      res_q     <= res_d;
      flg_q     <= flg_d;
      psr_q     <= psr_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      ready_q   <= ready_d;
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: plays the external ALU and checks against an instruction-level model.
// Honors ALU_SEQ_R0_ZERO_EN the same way as the design build.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [7:0]  instr_op = '0;
  logic [3:0]  instr_rdest = '0;
  logic [3:0]  instr_rsrc = '0;
  logic [7:0]  instr_imm = '0;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [7:0]  alu_op;
  logic [4:0]  alu_flags, psr;
  logic        done, illegal;
  logic [3:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_rf [16];
  logic [4:0]  m_psr;

  const logic [7:0] legal_ops [25] = '{
    8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
    8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
    8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0};

  alu_seq_ctrl #(.NREGS(16), .W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rdest(instr_rdest), .instr_rsrc(instr_rsrc), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .psr(psr), .done(done), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: {flags{L,C,F,Z,N}, result}
  function automatic logic [20:0] alu_fn(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    c = 1'b0;
    case (op)
      8'h05, 8'h50: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
      8'h0B, 8'hB0: begin s = {1'b0, a} - {1'b0, b}; r = s[15:0]; c = s[16]; end
      8'h0D, 8'hD0: r = b;
      8'hC0:        r = {a[7:0], b[7:0]};
      default:      r = a ^ b ^ {8'h00, op};
    endcase
    return {(a < b), c, r[15] ^ a[15], (r == 16'h0000), r[15], r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_fn(alu_op, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [7:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] m_read(input logic [3:0] r);
`ifdef ALU_SEQ_R0_ZERO_EN
    if (r == 4'd0) return 16'h0000;
`endif
    return m_rf[r];
  endfunction

  function automatic logic [15:0] m_bop(input logic [7:0] op, input logic [3:0] rs, input logic [7:0] imm);
    return (op < 8'h10) ? m_read(rs) : {{8{imm[7]}}, imm};
  endfunction

  task automatic m_apply(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs, input logic [7:0] imm);
    logic [20:0] fr;
    fr = alu_fn(op, m_read(rd), m_bop(op, rs, imm));
    if (is_legal(op) && op != 8'h00) begin
      m_psr = fr[20:16];
      if (op != 8'h0B && op != 8'hB0) m_rf[rd] = fr[15:0];
    end
  endtask

  task automatic m_reset();
    foreach (m_rf[i]) m_rf[i] = '0;
    m_psr = '0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] r);
    dbg_addr = r;
    #1;
    chk(tag, {16'h0, dbg_data}, {16'h0, m_read(r)});
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {31'h0, instr_ready}, 32'h1);
  endtask

  // One instruction through the full handshake with per-cycle checks.
  task automatic run_instr(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs, input logic [7:0] imm);
    wait_ready();
    instr_valid = 1'b1; instr_op = op; instr_rdest = rd; instr_rsrc = rs; instr_imm = imm;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr_op = 8'h00; instr_rdest = 4'd0; instr_rsrc = 4'd0; instr_imm = 8'h00;
    chk("exec_ready", {31'h0, instr_ready}, 32'h0);
    chk("exec_done", {31'h0, done}, 32'h0);
    chk("exec_op", {24'h0, alu_op}, {24'h0, op});
    chk("exec_a", {16'h0, alu_a}, {16'h0, m_read(rd)});
    chk("exec_b", {16'h0, alu_b}, {16'h0, m_bop(op, rs, imm)});
    @(negedge clk);
    chk("wb_done", {31'h0, done}, 32'h1);
    chk("wb_illegal", {31'h0, illegal}, {31'h0, !is_legal(op)});
    chk("wb_ready", {31'h0, instr_ready}, 32'h0);
    @(negedge clk);
    chk("post_done", {31'h0, done}, 32'h0);
    chk("post_ready", {31'h0, instr_ready}, 32'h1);
    m_apply(op, rd, rs, imm);
    chk("psr", {27'h0, psr}, {27'h0, m_psr});
    read_chk("rf_dest", rd);
  endtask

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) read_chk("reset_rf", 4'(i));
    chk("reset_psr", {27'h0, psr}, 32'h0);
    chk("reset_ready", {31'h0, instr_ready}, 32'h1);
    chk("reset_done", {31'h0, done}, 32'h0);

    run_instr(8'h50, 4'd1, 4'd0, 8'h05);
    chk("addi_r1", {16'h0, m_read(4'd1)}, 32'h5);
    run_instr(8'h05, 4'd2, 4'd1, 8'h00);
    read_chk("add_r2", 4'd2);
    chk("add_r2_val", {16'h0, m_read(4'd2)}, 32'h5);
    run_instr(8'h05, 4'd1, 4'd1, 8'h00);
    chk("add_r1r1_val", {16'h0, m_read(4'd1)}, 32'hA);

    run_instr(8'hD0, 4'd3, 4'd0, 8'hFF);
    chk("movi_n", {31'h0, psr[0]}, 32'h1);
    chk("movi_r3_val", {16'h0, m_read(4'd3)}, 32'hFFFF);
    run_instr(8'hB0, 4'd3, 4'd0, 8'hFF);
    chk("cmpi_z", {31'h0, psr[1]}, 32'h1);
    chk("cmpi_r3_val", {16'h0, m_read(4'd3)}, 32'hFFFF);

    run_instr(8'hD0, 4'd4, 4'd0, 8'h12);
    run_instr(8'hC0, 4'd4, 4'd0, 8'h34);
    chk("r4_val", {16'h0, m_read(4'd4)}, 32'h1234);
    chk("psr_nonzero", {31'h0, psr != 5'd0}, 32'h1);
    run_instr(8'h0A, 4'd4, 4'd1, 8'h00);
    run_instr(8'hA0, 4'd4, 4'd0, 8'h11);
    chk("illegal_r4_val", {16'h0, m_read(4'd4)}, 32'h1234);

`ifdef ALU_SEQ_R0_ZERO_EN
    run_instr(8'hD0, 4'd0, 4'd0, 8'h09);
    chk("r0_psr_z", {31'h0, psr[1]}, 32'h0);
    read_chk("r0_zero", 4'd0);
`endif

    // Back-to-back with valid held high: handshakes in cycles 0, 3, 6.
    wait_ready();
    instr_valid = 1'b1; instr_op = 8'h50; instr_rdest = 4'd6; instr_rsrc = 4'd0; instr_imm = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("held_ready", {31'h0, instr_ready}, {31'h0, (k % 3) == 0});
      chk("held_done", {31'h0, done}, {31'h0, (k % 3) == 2});
      if (k == 7) instr_valid = 1'b0;
    end
    @(negedge clk);
    repeat (3) m_apply(8'h50, 4'd6, 4'd0, 8'h01);
    read_chk("held_r6", 4'd6);
    chk("held_psr", {27'h0, psr}, {27'h0, m_psr});

    for (int n = 0; n < 60; n++) begin
      logic [7:0] op;
      op = ($urandom_range(0, 1) == 0) ? legal_ops[$urandom_range(0, 24)] : 8'($urandom);
      run_instr(op, 4'($urandom), 4'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 16; i++) read_chk("sweep_rf", 4'(i));

    // Reset during EXEC aborts the instruction.
    wait_ready();
    instr_valid = 1'b1; instr_op = 8'hD0; instr_rdest = 4'd5; instr_rsrc = 4'd0; instr_imm = 8'h07;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("abort_in_exec", {31'h0, instr_ready}, 32'h0);
    reset_n = 1'b0;
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", {31'h0, done}, 32'h0);
      chk("abort_ready", {31'h0, instr_ready}, 32'h1);
    end
    read_chk("abort_r5", 4'd5);
    chk("abort_psr", {27'h0, psr}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
